instr_prefetch_queue: RTL

Upstream fetch stage for the multi-cycle 8-bit MIPS-subset processor. Walks a program from PC 0 to `max_pc-1`, reads 32-bit words from a synchronous 1-cycle-latency instruction ROM, predecodes each word and buffers it in a small FIFO. The processor pulls words over a valid/ready handshake instead of indexing instruction storage directly. Supports full-rate streaming, back-pressure and flush/restart.

---
 rtl/instr_fetch_pkg.sv | 28 ++
 rtl/instr_fifo.sv | 62 ++++++
 rtl/instr_prefetch_queue.sv | 138 +++++++++++++
 3 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction prefetch path: opcode/funct
// constants of the supported MIPS subset, the fetch FSM states and the
// predecode helper used when a ROM word enters the queue.
package instr_fetch_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN,
        ST_DONE
    } fetch_state_t;

    // Returns {is_r, illegal}. Only addu, subu and addiu are executable.
    function automatic logic [1:0] predecode(input logic [31:0] word);
        logic is_r;
        logic legal;
        is_r  = (word[31:26] == OP_RTYPE);
        legal = (is_r && ((word[5:0] == FN_ADDU) || (word[5:0] == FN_SUBU)))
                || (word[31:26] == OP_ADDIU);
        return {is_r, ~legal};
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Small synchronous FIFO holding predecoded instruction entries.
// Clear has priority over push/pop; a push while full is only taken
// when a pop frees the head slot in the same cycle.
module instr_fifo
    import instr_fetch_pkg::*;
#(
    parameter int WIDTH = 37,
    parameter int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(DEPTH));
    assign do_push   = push && (!full || pop);
    assign do_pop    = pop && !empty;
    assign head_data = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage needs no reset: an entry is only visible once counted.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/instr_prefetch_queue.sv
// Fetch stage: walks PC 0..max_pc-1 through a 1-cycle-latency ROM,
// predecodes each returning word and queues it for the processor behind
// a valid/ready handshake. Reads are credit-limited so the queue can
// never overflow, and flush/reset discard any response still on the bus.
module instr_prefetch_queue
    import instr_fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PC_W  = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            flush,
    input  logic [PC_W-1:0] max_pc,
    output logic            mem_en,
    output logic [PC_W-1:0] mem_addr,
    input  logic [31:0]     mem_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr_data,
    output logic [PC_W-1:0] instr_pc,
    output logic            instr_is_r,
    output logic            instr_illegal,
    output logic            busy,
    output logic            done
);

    localparam int ENTRY_W = 32 + PC_W + 2;
    localparam int CNT_W   = $clog2(DEPTH) + 1;

    fetch_state_t     state;
    fetch_state_t     state_next;
    logic             load_run;
    logic [PC_W-1:0]  fetch_pc;
    logic [PC_W-1:0]  max_pc_q;
    logic             inflight_q;
    logic [PC_W-1:0]  issue_pc_q;

    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty;
    logic [ENTRY_W-1:0] head_data;
    logic [ENTRY_W-1:0] push_data;
    logic             push;
    logic             pop;
    logic [CNT_W:0]   credit_used;
    logic             credit_ok;
    logic             drain_empty;

    // Credits count both queued entries and the read whose data is on the bus.
    assign credit_used = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
    assign credit_ok   = credit_used < (CNT_W + 1)'(DEPTH);

    assign mem_en   = (state == ST_FETCH) && !flush && (fetch_pc < max_pc_q) && credit_ok;
    assign mem_addr = (state == ST_FETCH) ? fetch_pc : '0;

    // A response arriving during a flush cycle is dropped rather than pushed;
    // the gated mem_en guarantees nothing else is in flight afterwards.
    assign push      = inflight_q && !flush;
    assign push_data = {mem_rdata, issue_pc_q, predecode(mem_rdata)};
    assign pop       = instr_valid && instr_ready;

    // The queue is about to be empty with nothing outstanding, so the
    // final pop and the move to DONE share one edge.
    assign drain_empty = !inflight_q &&
                         ((fifo_count == '0) || ((fifo_count == CNT_W'(1)) && pop));

    instr_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (flush),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head_data (head_data),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Next-state logic; flush overrides everything including start.
    always_comb begin
        state_next = state;
        load_run   = 1'b0;
        if (flush) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        load_run   = 1'b1;
                        state_next = (max_pc == '0) ? ST_DONE : ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (mem_en && (fetch_pc == max_pc_q - PC_W'(1))) state_next = ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (drain_empty) state_next = ST_DONE;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // State, program counter and in-flight read tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            fetch_pc   <= '0;
            max_pc_q   <= '0;
            inflight_q <= 1'b0;
            issue_pc_q <= '0;
        end else begin
            state      <= state_next;
            inflight_q <= mem_en;
            if (load_run) begin
                max_pc_q <= max_pc;
                fetch_pc <= '0;
            end else if (mem_en) begin
                fetch_pc <= fetch_pc + PC_W'(1);
            end
            if (mem_en) issue_pc_q <= fetch_pc;
        end
    end

    assign instr_valid   = !fifo_empty;
    assign instr_data    = instr_valid ? head_data[ENTRY_W-1 -: 32] : '0;
    assign instr_pc      = instr_valid ? head_data[PC_W+1:2]        : '0;
    assign instr_is_r    = instr_valid ? head_data[1]               : 1'b0;
    assign instr_illegal = instr_valid ? head_data[0]               : 1'b0;

    assign busy = (state == ST_FETCH) || (state == ST_DRAIN);
    assign done = (state == ST_DONE);

endmodule
